// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Sequences the ID-stage branch comparator. A branch in ID is held (Stall)
//   until its operands are final. The comparator operand is then registered
//   on CmpIn. In the following EVAL cycle the external zero flag (CmpZero)
//   resolves the branch and drives the PC redirect and the IF/ID flush.
//   The block also keeps saturating taken/stall statistics.
// Ports
//   Clk, Reset        clock; synchronous active-low reset
//   BranchValid       branch instruction present in ID
//   BranchType[2:0]   000 BEQ 001 BNE 010 BLEZ 011 BGTZ 100 BLTZ 101 BGEZ
//   BranchTarget      computed target from ID
//   OpA/OpB (+_Ready) post-forwarding operands and their final-value flags
//   KillIn            squash the in-flight branch
//   CmpZero           comparator flag, 1 when CmpIn == 0
//   CmpIn, TargetPC   registered comparator operand / branch target
//   Stall, Flush, PCSrc  combinational pipeline controls
//   BranchTaken, IllegalType  one-cycle resolution pulses
//   TakenCount, StallCount    saturating statistics
module branch_resolve_ctrl #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BranchValid,
  input  logic [2:0]        BranchType,
  input  logic [PC_W-1:0]   BranchTarget,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  input  logic              OpA_Ready,
  input  logic              OpB_Ready,
  input  logic              KillIn,
  input  logic              CmpZero,
  output logic [DATA_W-1:0] CmpIn,
  output logic              Stall,
  output logic              Flush,
  output logic              PCSrc,
  output logic [PC_W-1:0]   TargetPC,
  output logic              BranchTaken,
  output logic              IllegalType,
  output logic [CNT_W-1:0]  TakenCount,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

  state_t     state, nxt;
  logic [2:0] btype;     // latched branch type
  logic       sign;      // latched OpA sign bit
  logic [2:0] cur_type;  // type governing the current capture attempt
  logic       ready;
  logic       capture;
  logic       accept;
  logic       taken;

  // In IDLE the live type decides readiness; in WAIT the latched one does.
  always_comb begin
    cur_type = (state == IDLE) ? BranchType : btype;
    ready    = (cur_type[2:1] == 2'b00) ? (OpA_Ready & OpB_Ready) : OpA_Ready;
  end

  always_comb begin
    nxt         = state;
    Stall       = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    taken       = 1'b0;
    PCSrc       = 1'b0;
    Flush       = 1'b0;
    BranchTaken = 1'b0;
    IllegalType = 1'b0;
    case (state)
      IDLE: begin
        if (BranchValid && !KillIn) begin
          Stall   = 1'b1;
          accept  = 1'b1;
          capture = ready;
          nxt     = ready ? EVAL : WAIT;
        end
      end
      WAIT: begin
        // Kill wins over a capture landing in the same cycle.
        if (KillIn) begin
          nxt = IDLE;
        end else begin
          Stall   = 1'b1;
          capture = ready;
          if (ready) nxt = EVAL;
        end
      end
      EVAL: begin
        nxt = IDLE;
        case (btype)
          3'd0:    taken = CmpZero;
          3'd1:    taken = !CmpZero;
          3'd2:    taken = sign | CmpZero;
          3'd3:    taken = !sign & !CmpZero;
          3'd4:    taken = sign;
          3'd5:    taken = !sign;
          default: taken = 1'b0;
        endcase
        if (!KillIn) begin
          PCSrc       = taken;
          Flush       = taken;
          BranchTaken = taken;
          IllegalType = (btype[2:1] == 2'b11);
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      btype      <= 3'd0;
      sign       <= 1'b0;
      CmpIn      <= '0;
      TargetPC   <= '0;
      TakenCount <= '0;
      StallCount <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        btype    <= BranchType;
        TargetPC <= BranchTarget;
      end
      if (capture) begin
        // BEQ/BNE compare via XOR so that CmpZero means "equal".
        CmpIn <= (cur_type[2:1] == 2'b00) ? (OpA ^ OpB) : OpA;
        sign  <= OpA[DATA_W-1];
      end
      if (BranchTaken && (TakenCount != '1)) TakenCount <= TakenCount + 1'b1;
      if (Stall && (StallCount != '1))       StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized bench for branch_resolve_ctrl. The reference model keeps the
// captured operands and resolves each branch with signed arithmetic compares.
// The counters are 4 bits wide so that saturation is reachable.
module tb_branch_resolve_ctrl;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          BranchValid;
  logic [2:0]    BranchType;
  logic [PW-1:0] BranchTarget;
  logic [DW-1:0] OpA, OpB;
  logic          OpA_Ready, OpB_Ready, KillIn;
  logic          CmpZero;
  logic [DW-1:0] CmpIn;
  logic          Stall, Flush, PCSrc, BranchTaken, IllegalType;
  logic [PW-1:0] TargetPC;
  logic [CW-1:0] TakenCount, StallCount;

  // External comparator: zero flag of the registered operand.
  assign CmpZero = (CmpIn == '0);

  branch_resolve_ctrl #(.DATA_W(DW), .PC_W(PW), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .BranchValid(BranchValid), .BranchType(BranchType),
    .BranchTarget(BranchTarget), .OpA(OpA), .OpB(OpB), .OpA_Ready(OpA_Ready),
    .OpB_Ready(OpB_Ready), .KillIn(KillIn), .CmpZero(CmpZero), .CmpIn(CmpIn),
    .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc), .TargetPC(TargetPC),
    .BranchTaken(BranchTaken), .IllegalType(IllegalType),
    .TakenCount(TakenCount), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: where the branch is (none / waiting for operands / resolving)
  // plus the values it captured.
  int          m_phase;   // 0 none, 1 waiting, 2 resolving
  logic [2:0]  m_type;
  logic [31:0] m_a, m_b, m_cmp, m_tpc;
  int          m_taken, m_stall;

  function automatic bit needs_ready(input logic [2:0] t, input logic ra, input logic rb);
    return (t == 3'd0 || t == 3'd1) ? (ra && rb) : ra;
  endfunction

  function automatic bit resolves_taken(input logic [2:0] t, input logic [31:0] a,
                                        input logic [31:0] b);
    case (t)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) <= 0;
      3'd3: return $signed(a) > 0;
      3'd4: return $signed(a) < 0;
      3'd5: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic grab(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    m_a = a; m_b = b;
    m_cmp = (t == 3'd0 || t == 3'd1) ? (a ^ b) : a;
    m_phase = 2;
  endtask

  // One clock cycle: drive at negedge, check combinational and registered
  // outputs, then advance the model to what the coming posedge should produce.
  task automatic step(input logic bv, input logic [2:0] ty, input logic [31:0] tg,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic ra, input logic rb, input logic k, input logic rs);
    bit e_stall, e_tk, e_ill;
    @(negedge Clk);
    BranchValid = bv; BranchType = ty; BranchTarget = tg; OpA = a; OpB = b;
    OpA_Ready = ra; OpB_Ready = rb; KillIn = k; Reset = rs;
    #1;
    e_stall = !k && ((m_phase == 0 && bv) || m_phase == 1);
    e_tk    = (m_phase == 2) && !k && resolves_taken(m_type, m_a, m_b);
    e_ill   = (m_phase == 2) && !k && (m_type > 3'd5);
    chk("stall", Stall, e_stall);
    chk("pcsrc", PCSrc, e_tk);
    chk("flush", Flush, e_tk);
    chk("taken", BranchTaken, e_tk);
    chk("illegal", IllegalType, e_ill);
    chk("cmpin", CmpIn, m_cmp);
    chk("target", TargetPC, m_tpc);
    chk("takencnt", TakenCount, m_taken);
    chk("stallcnt", StallCount, m_stall);
    if (!rs) begin
      m_phase = 0; m_type = 0; m_a = 0; m_b = 0; m_cmp = 0; m_tpc = 0;
      m_taken = 0; m_stall = 0;
    end else begin
      if (e_stall && m_stall < CMAX) m_stall++;
      if (e_tk && m_taken < CMAX) m_taken++;
      case (m_phase)
        0: if (bv && !k) begin
             m_type = ty; m_tpc = tg;
             if (needs_ready(ty, ra, rb)) grab(ty, a, b);
             else m_phase = 1;
           end
        1: if (k) m_phase = 0;
           else if (needs_ready(m_type, ra, rb)) grab(m_type, a, b);
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic idle_cyc();
    step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  int sv_t, sv_s;

  initial begin
    m_phase = 0; m_type = 0; m_a = 0; m_b = 0; m_cmp = 0; m_tpc = 0;
    m_taken = 0; m_stall = 0;
    BranchValid = 0; BranchType = 0; BranchTarget = 0; OpA = 0; OpB = 0;
    OpA_Ready = 0; OpB_Ready = 0; KillIn = 0; Reset = 0;

    // Reset held two cycles, then released.
    step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    chk("rst_cmpin", CmpIn, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_cnt", {TakenCount, StallCount}, 0);

    // BEQ with equal operands, both ready: one stall, then redirect.
    step(1'b1, 3'd0, 32'h0000_4000, 32'h1234, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("beq_stall", Stall, 1);
    idle_cyc();
    chk("beq_pcsrc", PCSrc, 1);
    chk("beq_target", TargetPC, 32'h0000_4000);
    idle_cyc();
    chk("beq_tcnt", TakenCount, 1);
    chk("beq_scnt", StallCount, 1);

    // BNE with equal operands, OpB late by 3 cycles: 4 stalls, not taken.
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd1, 32'h0000_5000, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 32'h0000_5000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_cyc();
    chk("bne_pcsrc", PCSrc, 0);
    idle_cyc();
    chk("bne_scnt", StallCount, 5);
    chk("bne_tcnt", TakenCount, 1);

    // Sign/zero branches.
    step(1'b1, 3'd2, 32'h100, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cyc(); chk("blez_neg", PCSrc, 1);
    step(1'b1, 3'd3, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cyc(); chk("bgtz_zero", PCSrc, 0);
    step(1'b1, 3'd5, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cyc(); chk("bgez_zero", PCSrc, 1);

    // BGTZ parked in WAIT, then killed.
    step(1'b1, 3'd3, 32'h400, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd3, 32'h400, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    sv_t = m_taken; sv_s = m_stall;
    step(1'b0, 3'd3, 32'h400, 32'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("kill_pcsrc", PCSrc, 0);
    chk("kill_stall", Stall, 0);
    idle_cyc();
    chk("kill_tcnt", TakenCount, sv_t);
    chk("kill_scnt", StallCount, sv_s);

    // Saturation: 17 taken BEQs on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 3'd0, 32'h500 + i, i, i, 1'b1, 1'b1, 1'b0, 1'b1);
      idle_cyc();
    end
    idle_cyc();
    chk("sat_tcnt", TakenCount, CMAX);
    chk("sat_scnt", StallCount, CMAX);

    // Illegal type 111.
    step(1'b1, 3'd7, 32'h600, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_cyc();
    chk("ill_pulse", IllegalType, 1);
    chk("ill_pcsrc", PCSrc, 0);

    // Reset mid-branch, then random traffic.
    step(1'b1, 3'd4, 32'h700, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    chk("midrst_pcsrc", PCSrc, 0);
    chk("midrst_cnt", {TakenCount, StallCount}, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      int sel;
      sel = $urandom_range(0, 3);
      a = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 | $urandom_range(0, 15) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? $urandom : a;
      step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom, a, b,
           $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
